// File: rtl/counter_control_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_control_gen_if
// Description : Bundles the four raw panel buttons and the strobe set handed
//               to the pattern-generator counter bank.
//               master : drives the buttons, observes the strobes (board side)
//               slave  : counter_control_gen itself
// Revision    : 1.0  initial release
// ============================================================================
interface counter_control_gen_if;
    logic btn_sel;      // raw async button: advance counter selection
    logic btn_up;       // raw async button: increment selected counter
    logic btn_dn;       // raw async button: decrement selected counter
    logic btn_clr;      // raw async button: clear selected counter
    logic selector;     // select strobe
    logic incrementor;  // count strobe, direction given by reverse
    logic reverse;      // 1 = count strobe decrements
    logic clr;          // clear strobe
    logic busy;         // sequencer is outside IDLE

    modport master (
        output btn_sel, btn_up, btn_dn, btn_clr,
        input  selector, incrementor, reverse, clr, busy
    );

    modport slave (
        input  btn_sel, btn_up, btn_dn, btn_clr,
        output selector, incrementor, reverse, clr, busy
    );
endinterface
`default_nettype wire

// File: rtl/counter_control_gen.sv
`default_nettype none
// ============================================================================
// Module      : counter_control_gen
// Description : Turns four raw panel buttons into non-overlapping, registered
//               strobes for the counter bank. Each button is synchronised,
//               debounced and rising-edge detected; the resulting events are
//               held in one pending flag per button and replayed one at a time
//               (priority clr > sel > up > dn) as SETUP / PULSE / GAP.
// Ports       : clk        - system clock, sole domain
//               reset_n    - synchronous active-low reset
//               bus        - counter_control_gen_if.slave
//                            (btn_sel/up/dn/clr in; selector, incrementor,
//                             reverse, clr, busy out)
// Options     : COUNTER_CONTROL_GEN_AUTO_REPEAT_EN - when defined, holding
//               up/dn auto-repeats after REPEAT_DELAY, then every
//               REPEAT_PERIOD cycles. Undefined: one event per press.
// Revision    : 1.0  initial release
// ============================================================================
module counter_control_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_LEN       = 4,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    counter_control_gen_if.slave bus
);

    // Button / kind numbering; the lowest index has the highest priority.
    localparam int         c_IDX_CLR  = 0;
    localparam int         c_IDX_SEL  = 1;
    localparam int         c_IDX_UP   = 2;
    localparam int         c_IDX_DN   = 3;
    localparam logic [1:0] c_KIND_CLR = 2'd0;
    localparam logic [1:0] c_KIND_SEL = 2'd1;
    localparam logic [1:0] c_KIND_UP  = 2'd2;
    localparam logic [1:0] c_KIND_DN  = 2'd3;

    localparam int                c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);

    localparam int                c_PL_W    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [c_PL_W-1:0] c_PL_LAST = c_PL_W'(PULSE_LEN - 1);
    localparam logic [c_PL_W-1:0] c_PL_ONE  = c_PL_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_PULSE = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    // Parameter sanity checks. The repeat values are checked in both builds
    // so a bad override is caught before the feature is switched on.
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (PULSE_LEN < 1) begin : g_chk_pulse
        $error("PULSE_LEN must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [3:0] w_btn_raw;
    logic [3:0] w_press;
    logic [3:0] w_event;
`ifdef COUNTER_CONTROL_GEN_AUTO_REPEAT_EN
    logic [3:0] w_db_level;
`endif

    assign w_btn_raw[c_IDX_CLR] = bus.btn_clr;
    assign w_btn_raw[c_IDX_SEL] = bus.btn_sel;
    assign w_btn_raw[c_IDX_UP]  = bus.btn_up;
    assign w_btn_raw[c_IDX_DN]  = bus.btn_dn;

    // ------------------------------------------------------------------
    // Per-button synchroniser, debouncer and press detector
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_btn
        logic [1:0]        r_sync;
        logic [c_DB_W-1:0] r_db_cnt;
        logic              r_db_level;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_sync     <= 2'b00;
                r_db_cnt   <= '0;
                r_db_level <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_btn_raw[gi]};
                // The counter only runs while the synced level disagrees with
                // the accepted level; any return to agreement restarts it.
                if (r_sync[1] == r_db_level) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    r_db_cnt   <= '0;
                    r_db_level <= r_sync[1];
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_ONE;
                end
            end
        end

        // Press is flagged in the same cycle the debounced level rises, so
        // the pending flag and the debounced level update together.
        assign w_press[gi] = r_sync[1] && !r_db_level && (r_db_cnt == c_DB_LAST);
`ifdef COUNTER_CONTROL_GEN_AUTO_REPEAT_EN
        assign w_db_level[gi] = r_db_level;
`endif
    end

    // ------------------------------------------------------------------
    // Optional auto-repeat for up/dn
    // ------------------------------------------------------------------
`ifdef COUNTER_CONTROL_GEN_AUTO_REPEAT_EN
    localparam int                c_RP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                c_RP_W    = (c_RP_MAX > 1) ? $clog2(c_RP_MAX) : 1;
    localparam logic [c_RP_W-1:0] c_RD_LAST = c_RP_W'(REPEAT_DELAY - 1);
    localparam logic [c_RP_W-1:0] c_RP_LAST = c_RP_W'(REPEAT_PERIOD - 1);
    localparam logic [c_RP_W-1:0] c_RP_ONE  = c_RP_W'(1);

    logic [1:0] w_repeat;

    genvar gr;
    for (gr = c_IDX_UP; gr <= c_IDX_DN; gr++) begin : g_rep
        logic [c_RP_W-1:0] r_rep_cnt;
        logic              r_rep_armed;   // initial delay has elapsed
        logic              w_rep_fire;

        assign w_rep_fire = w_db_level[gr] &&
                            ((!r_rep_armed && (r_rep_cnt == c_RD_LAST)) ||
                             ( r_rep_armed && (r_rep_cnt == c_RP_LAST)));

        // Held at zero while the debounced level is low, so counting starts
        // from zero on the cycle after the press event.
        always_ff @(posedge clk) begin
            if (!reset_n || !w_db_level[gr]) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
            end else if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + c_RP_ONE;
            end
        end

        assign w_repeat[gr - c_IDX_UP] = w_rep_fire;
    end

    assign w_event = w_press | {w_repeat, 2'b00};
`else
    assign w_event = w_press;
`endif

    // ------------------------------------------------------------------
    // Pending flags: set wins over the clear issued by the sequencer
    // ------------------------------------------------------------------
    logic [3:0] r_pend;
    logic [3:0] w_pend_clr;
    logic [3:0] w_pick;
    logic [1:0] w_pick_kind;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend <= 4'b0000;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_event;
        end
    end

    assign w_pick[c_IDX_CLR] = r_pend[c_IDX_CLR];
    assign w_pick[c_IDX_SEL] = r_pend[c_IDX_SEL] && !r_pend[c_IDX_CLR];
    assign w_pick[c_IDX_UP]  = r_pend[c_IDX_UP]  && !r_pend[c_IDX_CLR] && !r_pend[c_IDX_SEL];
    assign w_pick[c_IDX_DN]  = r_pend[c_IDX_DN]  && !r_pend[c_IDX_CLR] && !r_pend[c_IDX_SEL]
                                                 && !r_pend[c_IDX_UP];

    assign w_pick_kind = w_pick[c_IDX_CLR] ? c_KIND_CLR :
                         w_pick[c_IDX_SEL] ? c_KIND_SEL :
                         w_pick[c_IDX_UP]  ? c_KIND_UP  : c_KIND_DN;

    // ------------------------------------------------------------------
    // Strobe sequencer
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [c_PL_W-1:0] r_cnt;
    logic [1:0]        r_kind;
    logic              r_reverse;
    logic              r_selector;
    logic              r_incrementor;
    logic              r_clr;

    logic [1:0]        w_state_nxt;
    logic [c_PL_W-1:0] w_cnt_nxt;
    logic [1:0]        w_kind_nxt;
    logic              w_reverse_nxt;
    logic              w_strobe_nxt;
    logic              w_selector_nxt;
    logic              w_incrementor_nxt;
    logic              w_clr_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_kind        <= c_KIND_CLR;
            r_reverse     <= 1'b0;
            r_selector    <= 1'b0;
            r_incrementor <= 1'b0;
            r_clr         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_kind        <= w_kind_nxt;
            r_reverse     <= w_reverse_nxt;
            r_selector    <= w_selector_nxt;
            r_incrementor <= w_incrementor_nxt;
            r_clr         <= w_clr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_kind_nxt    = r_kind;
        w_reverse_nxt = r_reverse;
        w_strobe_nxt  = 1'b0;
        w_pend_clr    = 4'b0000;

        case (r_state)
            c_ST_IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = c_ST_SETUP;
                    w_kind_nxt  = w_pick_kind;
                    w_pend_clr  = w_pick;
                    // reverse is updated on entry to SETUP so it is already
                    // settled for the whole cycle before the strobe rises;
                    // sel/clr leave it untouched.
                    if (w_pick_kind == c_KIND_UP) begin
                        w_reverse_nxt = 1'b0;
                    end else if (w_pick_kind == c_KIND_DN) begin
                        w_reverse_nxt = 1'b1;
                    end
                end
            end
            c_ST_SETUP: begin
                w_state_nxt  = c_ST_PULSE;
                w_cnt_nxt    = '0;
                w_strobe_nxt = 1'b1;
            end
            c_ST_PULSE: begin
                if (r_cnt == c_PL_LAST) begin
                    w_state_nxt = c_ST_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt    = r_cnt + c_PL_ONE;
                    w_strobe_nxt = 1'b1;
                end
            end
            default: begin  // c_ST_GAP
                if (r_cnt == c_PL_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_PL_ONE;
                end
            end
        endcase

        // r_kind is stable from SETUP through PULSE, so decoding it here
        // cannot glitch the registered strobes.
        w_selector_nxt    = w_strobe_nxt && (r_kind == c_KIND_SEL);
        w_clr_nxt         = w_strobe_nxt && (r_kind == c_KIND_CLR);
        w_incrementor_nxt = w_strobe_nxt && ((r_kind == c_KIND_UP) || (r_kind == c_KIND_DN));
    end

    assign bus.selector    = r_selector;
    assign bus.incrementor = r_incrementor;
    assign bus.clr         = r_clr;
    assign bus.reverse     = r_reverse;
    assign bus.busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
